// File: rtl/common.sv
// rtl/common.sv - constants shared across the pipeline
package common;

    localparam logic [31:0] PC_RESET = 32'hBFC0_0000;

endpackage

// File: rtl/pipes.sv
// rtl/pipes.sv - pipeline register and fetch FSM types
package pipes;

    typedef struct packed {
        logic [31:0] instruction;
        logic [31:0] pc_plus_4;
        logic        valid;
    } f_d_reg_t;

    typedef enum logic [1:0] {
        REQ,
        HOLD,
        FLUSH
    } fetch_state_t;

    typedef enum logic [1:0] {
        PC_KEEP,
        PC_REDIRECT,
        PC_ADV
    } pc_sel_t;

    typedef enum logic [1:0] {
        RA_KEEP,
        RA_REDIRECT,
        RA_ADV,
        RA_PC
    } ra_sel_t;

endpackage

// File: rtl/fetch_if.sv
// rtl/fetch_if.sv - instruction bus, redirect and fetch-to-decode signals
interface fetch_if;
    import pipes::*;

    logic        ireq_valid;
    logic [31:0] ireq_addr;
    logic        iresp_data_ok;
    logic [31:0] iresp_data;
    logic        stallF;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    f_d_reg_t    f_d_reg;

    modport master (
        output ireq_valid, ireq_addr, f_d_reg,
        input  iresp_data_ok, iresp_data, stallF, redirect_valid, redirect_pc
    );

    modport slave (
        input  ireq_valid, ireq_addr, f_d_reg,
        output iresp_data_ok, iresp_data, stallF, redirect_valid, redirect_pc
    );

endinterface

// File: rtl/fetch_pc_reg.sv
// rtl/fetch_pc_reg.sv - next fetch pc and outstanding request address
module fetch_pc_reg
    import pipes::*;
    import common::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  pc_sel_t     pc_sel,
    input  ra_sel_t     ra_sel,
    input  logic [31:0] redirect_pc,
    input  logic [31:0] adv_addr,
    output logic [31:0] req_addr
);

    logic [31:0] pc;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            pc       <= PC_RESET;
            req_addr <= PC_RESET;
        end else begin
            case (pc_sel)
                PC_REDIRECT: pc <= redirect_pc;
                PC_ADV:      pc <= adv_addr;
                default:     pc <= pc;
            endcase
            // RA_PC reissues at the pc parked during a flush
            case (ra_sel)
                RA_REDIRECT: req_addr <= redirect_pc;
                RA_ADV:      req_addr <= adv_addr;
                RA_PC:       req_addr <= pc;
                default:     req_addr <= req_addr;
            endcase
        end
    end

endmodule

// File: rtl/fetch.sv
// rtl/fetch.sv - instruction fetch stage: bus requests, stall buffering, redirects
module fetch
    import pipes::*;
(
    input  logic    clk,
    input  logic    resetn,
    fetch_if.master bus
);

    fetch_state_t state;
    logic [31:0]  hold_inst;
    logic [31:0]  hold_pc4;
    logic [31:0]  req_addr;
    logic [31:0]  seq_addr;
    logic [31:0]  adv_addr;
    pc_sel_t      pc_sel;
    ra_sel_t      ra_sel;
    f_d_reg_t     fd;

    assign seq_addr       = req_addr + 32'd4;
    assign bus.ireq_addr  = req_addr;
    assign bus.ireq_valid = resetn && (state != HOLD);
    assign bus.f_d_reg    = fd;

    always_comb begin
        pc_sel   = PC_KEEP;
        ra_sel   = RA_KEEP;
        adv_addr = seq_addr;
        fd       = '0;
        case (state)
            REQ: begin
                fd.instruction = bus.iresp_data;
                fd.pc_plus_4   = seq_addr;
                fd.valid       = bus.iresp_data_ok && !bus.stallF && !bus.redirect_valid;
                if (bus.redirect_valid) begin
                    pc_sel = PC_REDIRECT;
                    ra_sel = bus.iresp_data_ok ? RA_REDIRECT : RA_KEEP;
                end else if (bus.iresp_data_ok && !bus.stallF) begin
                    pc_sel = PC_ADV;
                    ra_sel = RA_ADV;
                end
            end
            HOLD: begin
                fd.instruction = hold_inst;
                fd.pc_plus_4   = hold_pc4;
                fd.valid       = !bus.redirect_valid;
                adv_addr       = hold_pc4;
                if (bus.redirect_valid) begin
                    pc_sel = PC_REDIRECT;
                    ra_sel = RA_REDIRECT;
                end else if (!bus.stallF) begin
                    pc_sel = PC_ADV;
                    ra_sel = RA_ADV;
                end
            end
            FLUSH: begin
                if (bus.redirect_valid) begin
                    pc_sel = PC_REDIRECT;
                end else if (bus.iresp_data_ok) begin
                    ra_sel = RA_PC;
                end
            end
            default: begin
                pc_sel = PC_KEEP;
            end
        endcase
        if (!resetn) begin
            fd = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= REQ;
            hold_inst <= '0;
            hold_pc4  <= '0;
        end else begin
            case (state)
                REQ: begin
                    if (bus.redirect_valid) begin
                        state <= bus.iresp_data_ok ? REQ : FLUSH;
                    end else if (bus.iresp_data_ok && bus.stallF) begin
                        state     <= HOLD;
                        hold_inst <= bus.iresp_data;
                        hold_pc4  <= seq_addr;
                    end
                end
                HOLD: begin
                    if (bus.redirect_valid || !bus.stallF) begin
                        state <= REQ;
                    end
                end
                FLUSH: begin
                    // a redirect here only retargets pc; the in-flight word still has to drain
                    if (!bus.redirect_valid && bus.iresp_data_ok) begin
                        state <= REQ;
                    end
                end
                default: state <= REQ;
            endcase
        end
    end

    fetch_pc_reg pc_reg (
        .clk         (clk),
        .resetn      (resetn),
        .pc_sel      (pc_sel),
        .ra_sel      (ra_sel),
        .redirect_pc (bus.redirect_pc),
        .adv_addr    (adv_addr),
        .req_addr    (req_addr)
    );

endmodule

// File: doc/fetch.md
FETCH -- requirements
Module: fetch

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 The block SHALL have port resetn, input, 1 bit: synchronous, active-low reset.
REQ-003 The block SHALL have port ireq_valid, output, 1 bit: an instruction-bus request is pending.
REQ-004 The block SHALL have port ireq_addr, output, 32 bits: the fetch address.
REQ-005 The block SHALL have port iresp_data_ok, input, 1 bit: the bus returns the data for the pending request this cycle.
REQ-006 The block SHALL have port iresp_data, input, 32 bits: the instruction word; valid only when iresp_data_ok=1.
REQ-007 The block SHALL have port stallF, input, 1 bit: decode cannot accept an instruction this cycle (same source as stallD).
REQ-008 The block SHALL have port redirect_valid, input, 1 bit: a taken branch resolved downstream.
REQ-009 The block SHALL have port redirect_pc, input, 32 bits: the branch target.
REQ-010 The block SHALL have port f_d_reg, output, type f_d_reg_t: fields instruction (32), pc_plus_4 (32), valid (1); presented combinationally, and registered by decode.

Function
REQ-011 The block SHALL hold a pc register (next fetch address) and a req_addr register (address of the outstanding request); ireq_addr SHALL equal req_addr.
REQ-012 The FSM SHALL have three states: REQ (request outstanding), HOLD (word buffered, waiting for decode), FLUSH (outstanding request must be discarded).
REQ-013 In REQ and FLUSH, ireq_valid SHALL be 1, and ireq_addr SHALL stay stable until iresp_data_ok; in HOLD, ireq_valid SHALL be 0.
REQ-014 In REQ with iresp_data_ok=1, stallF=0 and redirect_valid=0, the block SHALL present f_d_reg = {iresp_data, req_addr+4, valid=1} in that same cycle, set pc and req_addr to req_addr+4, and remain in REQ; the new request SHALL start the next cycle.
REQ-015 In REQ with iresp_data_ok=1, stallF=1 and redirect_valid=0, the block SHALL capture {iresp_data, req_addr+4} into a hold buffer and go to HOLD; f_d_reg.valid SHALL be 0 that cycle.
REQ-016 In HOLD, f_d_reg SHALL present the buffered word with valid=1; when stallF=0 the word is consumed, pc and req_addr SHALL become buffered pc_plus_4, and the FSM SHALL go to REQ.
REQ-017 In REQ with iresp_data_ok=0, f_d_reg.valid SHALL be 0 (bubble).
REQ-018 Redirect SHALL have priority over all other events: on redirect_valid=1, pc SHALL be loaded with redirect_pc, and f_d_reg.valid SHALL be 0 that cycle.
REQ-019 A redirect in REQ with iresp_data_ok=0 SHALL go to FLUSH; a redirect in REQ with iresp_data_ok=1 SHALL discard the word, set req_addr to redirect_pc, and stay in REQ.
REQ-020 A redirect in HOLD SHALL drop the buffer, set req_addr to redirect_pc, and go to REQ.
REQ-021 In FLUSH, the returning word SHALL be discarded (valid=0); on iresp_data_ok the block SHALL set req_addr to pc and go to REQ.
REQ-022 A redirect in FLUSH SHALL only update pc, and the FSM SHALL stay in FLUSH.
REQ-023 pc_plus_4 arithmetic SHALL be modulo 2^32; 0xFFFF_FFFC+4 SHALL wrap to 0x0000_0000.
REQ-024 No alignment checking SHALL be done; redirect_pc[1:0] SHALL pass through unchanged.

Reset
REQ-025 While resetn=0 at a clock edge, the block SHALL set the state to REQ, pc and req_addr to PC_RESET (0xBFC0_0000), and clear the hold buffer.
REQ-026 During the reset cycle, ireq_valid SHALL be 0 and f_d_reg SHALL be all zeros.
REQ-027 Reset mid-request SHALL abandon the outstanding request without flushing; the bus SHALL be reset in the same cycle.
REQ-028 In the first cycle after reset release, ireq_valid SHALL be 1 with ireq_addr=0xBFC0_0000.

Structure
REQ-029 The f_d_reg_t valid field SHALL be defined in pipes, and the fetch_state_t enum (REQ, HOLD, FLUSH) SHALL also be defined in pipes.
REQ-030 PC_RESET SHALL be defined in common.
REQ-031 The block SHALL contain one sub-module, pc_reg: the pc/req_addr registers with their next-value selection; the FSM and hold buffer SHALL stay in fetch.

Verification
REQ-032 Release reset; bus answers in 1 cycle with 0x2001_0005 -> ireq_addr=0xBFC0_0000; f_d_reg = {0x2001_0005, 0xBFC0_0004, 1}; next ireq_addr=0xBFC0_0004.
REQ-033 Data_ok with stallF=1 held 3 cycles -> ireq_valid=0 for 3 cycles; f_d_reg holds the same word (valid=1) during the stall; it is consumed when stallF drops; next request is at +4.
REQ-034 Redirect to 0x8000_0100 while a request is outstanding (data_ok 2 cycles later) -> the late word is discarded (valid=0); next ireq_addr=0x8000_0100.
REQ-035 Redirect and data_ok in the same cycle -> valid=0; next ireq_addr=redirect_pc.
REQ-036 Redirect while in HOLD -> buffer dropped; no valid output; next request at the target.
REQ-037 Redirect to 0xFFFF_FFFC, word returned -> pc_plus_4=0x0000_0000; next ireq_addr=0x0000_0000.
